sseg_scan_driver: RTL and testbench
===================================

Name: sseg_scan_driver

Overview:
Time-multiplexed scanner for a common-anode multi-digit seven-segment display. It sits directly upstream of the hex-to-seven-segment decoder. It holds a packed hex value, walks one digit per refresh period, and presents that digit's nibble to the decoder together with the active-low anode select. New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

Parameters:
DIGITS, 4, number of display digits (>=2)
CLK_DIV, 100000, clock cycles each digit stays lit (>=1)
DIV_W, 17, width of refresh counter; must satisfy 2^DIV_W >= CLK_DIV

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
load  input  1  single-cycle strobe: capture value
value  input  4*DIGITS  packed hex digits, digit 0 = bits [3:0] (rightmost)
blank_lz  input  1  1 = suppress leading zeros
nibble  output  4  current digit code, to decoder x input
an  output  DIGITS  active-low anode enables, one-hot-low
blank  output  1  1 = current digit dark (decoder output must be ignored)
pending  output  1  loaded value waiting for frame boundary

Behaviour:
- Reset (async assert, sync release):
  - div_cnt=0, idx=0, disp_reg=0, shadow=0.
  - Outputs: pending=0, an=all ones, nibble=0, blank=1.
- Refresh counter: div_cnt counts 0..CLK_DIV-1 and wraps to 0. tick=1 when div_cnt==CLK_DIV-1. With CLK_DIV=1, tick is 1 every cycle.
- Digit index: on tick, idx <= (idx==DIGITS-1) ? 0 : idx+1. A frame boundary is a tick with idx==DIGITS-1.
- Load handling:
  - load=1 alone: shadow <= value, pending <= 1. A later load before commit overwrites shadow (last load wins).
  - Frame boundary with pending=1: disp_reg <= shadow, pending <= 0.
  - load and frame boundary in the same cycle: disp_reg <= value (bypass), shadow <= value, pending <= 0.
  - load in the cycle after a boundary waits a full frame: DIGITS*CLK_DIV cycles.
- Outputs are registered and are a function of the current idx and disp_reg, so they lag the idx/disp_reg update by 1 cycle.
- Per-digit output for idx = i:
  - nibble = disp_reg[4i+3:4i].
  - lz(i) = blank_lz && i>0 && disp_reg[4*DIGITS-1:4i]==0.
  - If lz(i): an = all ones, blank=1.
  - Else: an = ~(1<<i), blank=0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- First rising edge after reset release drives an=~1 (digit 0), nibble=0, blank=0. With blank_lz=1 and disp_reg=0, digit 0 is still shown.
- Exactly one an bit is low at any time, or none when blanked. an never has two bits low in any cycle.
- blank_lz is sampled live, not double-buffered; a change takes effect on the next registered output.
- Reset mid-frame: immediate return to reset values. Pending value is discarded, disp_reg is cleared to 0.

Test Plan:
- CLK_DIV=4, DIGITS=4: reset, then load value=16'h1234. Required: pending=1 until the first frame boundary (cycle 15 after release). Next frame shows an=1110/nibble 4, 1101/3, 1011/2, 0111/1, each held exactly 4 cycles.
- Anti-tearing: load 16'hABCD mid-frame while 16'h1234 is displayed. Required: remaining digits of the current frame still show 1234 nibbles; 16'hABCD appears starting at digit 0 of the next frame; pending drops on the boundary cycle.
- Same-cycle load and frame boundary, value=16'h00F0. Required: pending never asserts (stays 0), and the next frame shows 00F0.
- blank_lz=1 with value=16'h0005: digits 3..1 give blank=1 and an=1111; digit 0 gives an=1110, nibble 5. With value=16'h0000: only digit 0 is lit, nibble 0. With value=16'h0100: digit 3 is blanked, digits 2, 1, 0 are lit.
- Assert rst for 1 cycle mid-frame with pending=1. Required: an=1111, blank=1, pending=0 immediately (asynchronously); after release, digit 0 shows nibble 0.
- CLK_DIV=1: the digit advances every cycle; an cycles 1110→1101→1011→0111→1110 with no repeated or skipped digit.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// Multiplexed scanner for a common-anode seven-segment display.
// Frame-aligned double buffering keeps every displayed frame coherent.
module sseg_scan_driver #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 100000,
  parameter int DIV_W   = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  blank,
  output logic                  pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW    = 4 * DIGITS;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VW-1:0]     disp_q, disp_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic              pend_q, pend_d;
  logic [3:0]        nib_q, nib_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              blank_q, blank_d;

  logic          tick;
  logic          fb;
  logic          lz;
  logic [VW-1:0] upper;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));
  assign fb   = tick && (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    // A load landing on the boundary bypasses the shadow wait.
    if (fb && load) begin
      disp_d   = value;
      shadow_d = value;
      pend_d   = 1'b0;
    end else if (fb && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end else if (load) begin
      shadow_d = value;
      pend_d   = 1'b1;
    end
  end

  always_comb begin
    upper   = disp_q >> {idx_q, 2'b00};
    lz      = blank_lz && (idx_q != '0) && (upper == '0);
    nib_d   = disp_q[{idx_q, 2'b00} +: 4];
    an_d    = lz ? '1 : ~(DIGITS'(1) << idx_q);
    blank_d = lz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      nib_q    <= '0;
      an_q     <= '1;
      blank_q  <= 1'b1;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      nib_q    <= nib_d;
      an_q     <= an_d;
      blank_q  <= blank_d;
    end
  end

  assign nibble  = nib_q;
  assign an      = an_q;
  assign blank   = blank_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: 4 digits, 4-cycle and 1-cycle dwell.
module tb_sseg_scan_driver;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        blank;
  logic        pending;

  logic        load1;
  logic [15:0] value1;
  logic        blank_lz1;
  logic [3:0]  nibble1;
  logic [3:0]  an1;
  logic        blank1;
  logic        pending1;

  int n_cmp;
  int n_err;

  sseg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .DIV_W(2)) u_dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .blank_lz(blank_lz), .nibble(nibble), .an(an),
    .blank(blank), .pending(pending)
  );

  sseg_scan_driver #(.DIGITS(4), .CLK_DIV(1), .DIV_W(1)) u_fast (
    .clk(clk), .rst(rst), .load(load1), .value(value1),
    .blank_lz(blank_lz1), .nibble(nibble1), .an(an1),
    .blank(blank1), .pending(pending1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [15:0] v, input logic lz,
                           input logic [15:0] an_exp,
                           input logic [3:0] bl_exp,
                           input int ld_cyc, input logic [15:0] ld_val,
                           input logic [15:0] pend_exp);
    blank_lz = lz;
    for (int j = 0; j < 16; j++) begin
      int d;
      d = j / 4;
      step();
      chk("an", {28'd0, an}, {28'd0, an_exp[4*d +: 4]});
      chk("nibble", {28'd0, nibble}, {28'd0, v[4*d +: 4]});
      chk("blank", {31'd0, blank}, {31'd0, bl_exp[d]});
      chk("pending", {31'd0, pending}, {31'd0, pend_exp[j]});
      load  = (j == ld_cyc);
      value = ld_val;
    end
  endtask

  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic [3:0] tbl [4];

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    load      = 1'b0;
    value     = '0;
    blank_lz  = 1'b0;
    load1     = 1'b0;
    value1    = '0;
    blank_lz1 = 1'b0;
    tbl[0] = 4'b1110;
    tbl[1] = 4'b1101;
    tbl[2] = 4'b1011;
    tbl[3] = 4'b0111;

    step();
    step();
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_nibble", {28'd0, nibble}, 32'h0);
    chk("rst_blank", {31'd0, blank}, 32'h1);
    chk("rst_pending", {31'd0, pending}, 32'h0);

    rst   = 1'b0;
    load  = 1'b1;
    value = 16'h1234;
    run_frame(16'h0000, 1'b0, AN_ALL, 4'b0000, -1, 16'h1234, 16'h7FFF);
    run_frame(16'h1234, 1'b0, AN_ALL, 4'b0000, 4, 16'hABCD, 16'h7FE0);
    run_frame(16'hABCD, 1'b0, AN_ALL, 4'b0000, 14, 16'h00F0, 16'h0000);
    run_frame(16'h00F0, 1'b0, AN_ALL, 4'b0000, 14, 16'h0005, 16'h0000);
    run_frame(16'h0005, 1'b1, {4'hF, 4'hF, 4'hF, 4'b1110}, 4'b1110,
              14, 16'h0000, 16'h0000);
    run_frame(16'h0000, 1'b1, {4'hF, 4'hF, 4'hF, 4'b1110}, 4'b1110,
              14, 16'h0100, 16'h0000);
    run_frame(16'h0100, 1'b1, {4'hF, 4'b1011, 4'b1101, 4'b1110}, 4'b1000,
              14, 16'h8888, 16'h0000);
    run_frame(16'h8888, 1'b1, AN_ALL, 4'b0000, -1, 16'h0000, 16'h0000);

    step();
    step();
    load  = 1'b1;
    value = 16'h1234;
    step();
    load  = 1'b0;
    chk("mid_pending", {31'd0, pending}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", {28'd0, an}, 32'hF);
    chk("arst_blank", {31'd0, blank}, 32'h1);
    chk("arst_pending", {31'd0, pending}, 32'h0);
    chk("arst_nibble", {28'd0, nibble}, 32'h0);
    step();
    rst = 1'b0;
    run_frame(16'h0000, 1'b1, {4'hF, 4'hF, 4'hF, 4'b1110}, 4'b1110,
              -1, 16'h0000, 16'h0000);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fast_an", {28'd0, an1}, {28'd0, tbl[k % 4]});
      chk("fast_blank", {31'd0, blank1}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
